// File: rtl/bcd_scan_display.sv
// Time-multiplexed 7-segment driver for NDIG snapshotted BCD digits, with
// optional leading-zero blanking and a sticky flag for non-BCD input.
module bcd_scan_display #(
   parameter int NDIG     = 4,
   parameter int SCAN_DIV = 4,
   parameter int BLANK_LZ = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic [4*NDIG-1:0] digits,
   output logic [6:0]        seg,
   output logic [NDIG-1:0]   an,
   output logic              err
);

   localparam int IW = $clog2(NDIG);
   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   logic [4*NDIG-1:0] snap_q, snap_d;
   logic [PW-1:0]     pre_q, pre_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [6:0]        seg_q, seg_d;
   logic [NDIG-1:0]   an_q, an_d;
   logic              err_q, err_d;

   logic [3:0] cur_dig;
   logic [6:0] dec;
   logic       bad_in;
   logic       nonzero_above;
   logic       blank;

   always_comb begin
      snap_d = load ? digits : snap_q;

      pre_d = pre_q + 1'b1;
      idx_d = idx_q;
      if (pre_q == PW'(SCAN_DIV - 1)) begin
         pre_d = '0;
         idx_d = (idx_q == IW'(NDIG - 1)) ? '0 : idx_q + 1'b1;
      end

      bad_in        = 1'b0;
      cur_dig       = '0;
      nonzero_above = 1'b0;
      for (int unsigned i = 0; i < NDIG; i++) begin
         if (digits[4*i +: 4] > 4'd9) bad_in = 1'b1;
         if (idx_q == IW'(i)) cur_dig = snap_q[4*i +: 4];
         // Any nonzero digit at or above the scan position keeps it lit.
         if ((IW'(i) >= idx_q) && (snap_q[4*i +: 4] != 4'd0)) nonzero_above = 1'b1;
      end

      err_d = err_q | (load & bad_in);

      case (cur_dig)
         4'd0:    dec = 7'h3F;
         4'd1:    dec = 7'h06;
         4'd2:    dec = 7'h5B;
         4'd3:    dec = 7'h4F;
         4'd4:    dec = 7'h66;
         4'd5:    dec = 7'h6D;
         4'd6:    dec = 7'h7D;
         4'd7:    dec = 7'h07;
         4'd8:    dec = 7'h7F;
         4'd9:    dec = 7'h6F;
         default: dec = 7'h00;
      endcase

      blank = (BLANK_LZ != 0) && (idx_q != '0) && !nonzero_above;
      seg_d = blank ? 7'h00 : dec;
      an_d  = NDIG'(1) << idx_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         snap_q <= '0;
         pre_q  <= '0;
         idx_q  <= '0;
         seg_q  <= '0;
         an_q   <= '0;
         err_q  <= 1'b0;
      end else begin
         snap_q <= snap_d;
         pre_q  <= pre_d;
         idx_q  <= idx_d;
         seg_q  <= seg_d;
         an_q   <= an_d;
         err_q  <= err_d;
      end
   end

   assign seg = seg_q;
   assign an  = an_q;
   assign err = err_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Self-checking bench for bcd_scan_display: directed scenarios plus random
// loads/resets, compared against an arithmetic model of the display.
module tb_bcd_scan_display;

   localparam int NDIG     = 4;
   localparam int SCAN_DIV = 4;
   localparam int DW       = 4 * NDIG;

   logic          clk = 1'b0;
   logic          reset;
   logic          load;
   logic [DW-1:0] digits;
   logic [6:0]    seg_a, seg_b;
   logic [NDIG-1:0] an_a, an_b;
   logic          err_a, err_b;

   int n_vec = 0;
   int n_bad = 0;

   logic [DW-1:0]   m_snap;
   int              m_cnt;
   logic            m_err;
   logic [NDIG-1:0] last_an;

   logic [6:0] seg_lut [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};

   always #5 clk = ~clk;

   bcd_scan_display #(.NDIG(NDIG), .SCAN_DIV(SCAN_DIV), .BLANK_LZ(1)) dut (
      .clk(clk), .reset(reset), .load(load), .digits(digits),
      .seg(seg_a), .an(an_a), .err(err_a)
   );

   bcd_scan_display #(.NDIG(NDIG), .SCAN_DIV(SCAN_DIV), .BLANK_LZ(0)) dut_nolz (
      .clk(clk), .reset(reset), .load(load), .digits(digits),
      .seg(seg_b), .an(an_b), .err(err_b)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
      end
   endtask

   // Number shown at position ix: the value above ix being zero means blank.
   function automatic logic [6:0] exp_seg(input logic [DW-1:0] s, input int ix, input bit blz);
      logic [DW-1:0] upper;
      logic [3:0]    d;
      upper = s >> (4 * ix);
      d     = upper[3:0];
      if (blz && ix != 0 && upper == '0) return 7'h00;
      return seg_lut[d];
   endfunction

   function automatic bit has_bad(input logic [DW-1:0] v);
      logic [DW-1:0] t;
      t = v;
      for (int i = 0; i < NDIG; i++) begin
         if (t[3:0] > 4'd9) return 1'b1;
         t = t >> 4;
      end
      return 1'b0;
   endfunction

   task automatic tick();
      logic [6:0]      es_a, es_b;
      logic [NDIG-1:0] ea;
      int              ix;
      if (reset) begin
         es_a = '0; es_b = '0; ea = '0;
      end else begin
         ix   = (m_cnt / SCAN_DIV) % NDIG;
         ea   = NDIG'(1) << ix;
         es_a = exp_seg(m_snap, ix, 1'b1);
         es_b = exp_seg(m_snap, ix, 1'b0);
      end
      @(posedge clk);
      #1;
      if (reset) begin
         m_snap = '0; m_cnt = 0; m_err = 1'b0;
      end else begin
         if (load && has_bad(digits)) m_err = 1'b1;
         if (load) m_snap = digits;
         m_cnt++;
      end
      check("an",       32'(an_a),  32'(ea));
      check("seg",      32'(seg_a), 32'(es_a));
      check("err",      32'(err_a), 32'(m_err));
      check("an_nolz",  32'(an_b),  32'(ea));
      check("seg_nolz", 32'(seg_b), 32'(es_b));
      check("err_nolz", 32'(err_b), 32'(m_err));
      last_an = ea;
   endtask

   task automatic do_load(input logic [DW-1:0] v, input int hold);
      load = 1'b1; digits = v;
      tick();
      load = 1'b0;
      repeat (hold) tick();
   endtask

   function automatic logic [DW-1:0] rand_digits();
      logic [DW-1:0] v;
      int            nz;
      v = '0;
      for (int i = 0; i < NDIG; i++) v = v | (DW'($urandom_range(0, 9)) << (4 * i));
      nz = $urandom_range(0, NDIG);
      for (int i = nz; i < NDIG; i++) v = v & ~(DW'(4'hF) << (4 * i));
      if ($urandom_range(0, 15) == 0) begin
         nz = $urandom_range(0, NDIG - 1);
         v  = (v & ~(DW'(4'hF) << (4 * nz))) | (DW'($urandom_range(10, 15)) << (4 * nz));
      end
      return v;
   endfunction

   initial begin
      bit found;
      m_snap = '0; m_cnt = 0; m_err = 1'b0; last_an = '0;

      // Reset dominant over a non-BCD load.
      reset = 1'b1; load = 1'b1; digits = 16'h9999;
      repeat (3) tick();
      reset = 1'b0; load = 1'b0;
      tick();
      check("first_an",  32'(an_a),  32'h1);
      check("first_seg", 32'(seg_a), 32'h3F);
      repeat (3) tick();

      // Scan order with a full number.
      do_load(16'h1234, 2 * NDIG * SCAN_DIV);

      // Leading-zero blanking.
      do_load(16'h0070, NDIG * SCAN_DIV);

      // Non-BCD nibble; err is sticky across a later valid load.
      do_load(16'h00A5, 0);
      check("err_set", 32'(err_a), 32'h1);
      repeat (NDIG * SCAN_DIV) tick();
      do_load(16'h0005, NDIG * SCAN_DIV);
      check("err_sticky", 32'(err_a), 32'h1);

      // Load mid-dwell: idx=0, pre=1 right after the first post-reset edge.
      reset = 1'b1; tick(); reset = 1'b0;
      tick();
      do_load(16'h0008, 1);
      check("middwell_seg", 32'(seg_a), 32'h7F);
      check("middwell_an",  32'(an_a),  32'h1);
      repeat (NDIG * SCAN_DIV) tick();

      // Reset mid-frame while digit 2 is lit.
      found = 1'b0;
      for (int k = 0; k < 4 * NDIG * SCAN_DIV && !found; k++) begin
         tick();
         if (last_an == NDIG'(4)) found = 1'b1;
      end
      check("midframe_reach", 32'(found), 32'h1);
      reset = 1'b1; tick(); reset = 1'b0;
      check("midframe_an0", 32'(an_a), 32'h0);
      repeat (SCAN_DIV) begin
         tick();
         check("restart_an", 32'(an_a), 32'h1);
      end
      repeat (NDIG * SCAN_DIV) tick();

      // Random loads, back-to-back loads and occasional resets.
      for (int k = 0; k < 600; k++) begin
         reset  = ($urandom_range(0, 59) == 0);
         load   = ($urandom_range(0, 5) == 0);
         digits = rand_digits();
         tick();
      end
      reset = 1'b0; load = 1'b0;
      repeat (2) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/bcd_scan_display.md
# bcd_scan_display

Downstream display stage for the decade-counter chain: it snapshots NDIG BCD digits produced by cascaded decade counters and drives them onto a single time-multiplexed 7-segment display. A prescaled scan counter selects one digit at a time. The block decodes that digit to segments, blanks leading zeros on request, and flags any non-BCD nibble it receives.

## Interface
Parameters:
- NDIG, 4: number of digits scanned (≥2)
- SCAN_DIV, 4: clock cycles each digit stays lit (≥1)
- BLANK_LZ, 1: 1 = blank leading zeros, 0 = show all digits

Ports:
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; one clock; reset is synchronous and active-high
- load  input  1  capture strobe for `digits`
- digits  input  4*NDIG  BCD digits; digit i = digits[4i+3:4i], digit 0 least significant
- seg  output  7  active-high segments {g,f,e,d,c,b,a}, registered
- an  output  NDIG  one-hot active-high digit enable, registered
- err  output  1  sticky non-BCD flag, registered

## Operation
- Snapshot register `snap`, 4*NDIG bits: loads `digits` on any edge with load=1; otherwise holds.
- Prescaler `pre`, 0..SCAN_DIV-1: increments every cycle and wraps to 0. When SCAN_DIV=1 it is always 0.
- Digit index `idx`, 0..NDIG-1: advances on the edge where pre==SCAN_DIV-1, wrapping from NDIG-1 to 0.
- Output register, updated every cycle (reset low) from current idx and snap:
  - an = one-hot(idx)
  - seg = decode(snap digit idx), or 0000000 if that digit is blanked
- Decode, hex {g..a}: 0→3F, 1→06, 2→5B, 3→4F, 4→66, 5→6D, 6→7D, 7→07, 8→7F, 9→6F. Nibbles 10–15 → 00 (blank).
- Leading-zero blank applies when BLANK_LZ=1, idx≠0, and every snap digit at index ≥ idx is 0. Digit 0 is never LZ-blanked.
- err goes high on the edge where load=1 and any nibble of `digits` is >9. It stays high until reset; later valid loads do not clear it.
- A load never disturbs pre or idx. Scanning continues with no glitch in the scan position.

## Timing
- Reset, synchronous and dominant over load in the same cycle. After the edge: snap=0, pre=0, idx=0, an=0 (all digits off), seg=0000000, err=0.
- First edge with reset=0: an=0001 (NDIG=4) and seg=3F, since snap=0 shows "0" on digit 0 and digits 1..3 are LZ-blanked.
- load→seg latency is 2 edges:
  - Edge 1 writes snap.
  - Edge 2 updates seg/an from the new snap.
- load→err latency is 1 edge.
- idx→an latency is 1 edge. After the first frame, each an pattern holds exactly SCAN_DIV cycles. Frame period = NDIG*SCAN_DIV cycles.
- Reset mid-frame: the next edge restores the full reset state. Scanning restarts at digit 0 with a full SCAN_DIV dwell.
- Back-to-back loads: each one overwrites snap. Displayed values follow with 2-edge latency.

## Test plan
- **Reset:** hold reset 3 cycles with load=1 and digits=16'h9999. Required: an=0, seg=00, err=0, snap=0. Then release reset with load=0 and observe an=0001, seg=3F.
- **Scan order, SCAN_DIV=4, NDIG=4:**
  - Stimulus: load 16'h1234, then capture an/seg over 32 cycles.
  - Required sequence: an 0001/seg 66 ("4"), 0010/4F, 0100/5B, 1000/06, each held 4 cycles, then repeating.
- **Leading-zero blanking:**
  - With 16'h0070: digit 1 → 07, digit 0 → 3F, digits 2 and 3 → 00.
  - Repeat with BLANK_LZ=0: digits 2 and 3 → 3F.
- **Non-BCD input:**
  - Load 16'h00A5. Required: err=1 the next cycle; digit 1 → 00 and is blanked; digit 0 → 6D.
  - Then load 16'h0005. Required: err stays 1 until reset.
- **Load mid-dwell:** load 16'h0008 while idx=0 and pre=1. Required: seg=7F two edges later, still within the same an=0001 dwell, and the an transition still occurs at the original cycle.
- **Reset mid-frame:** assert reset while an=0100. Required: an=0 on the next edge; after release, an=0001 held for SCAN_DIV cycles.
